// File: rtl/pcm_sampler_core_if.sv
// Slot bus between the CPU-side MMIO decoder and a slot core. The master drives
// strobes/address/write data; the slave returns combinational read data.
interface pcm_sampler_core_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/pcm_sampler_core.sv
// Decimated, optionally level-triggered capture of the DDFS PCM stream into a block-RAM
// buffer for CPU readback. Define PCM_SAMPLER_MINMAX_EN to add signed min/max tracking at addr 7.
module pcm_sampler_core #(
    parameter int W      = 16,
    parameter int ADDR_W = 10,
    parameter int DIV_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    pcm_sampler_core_if.slave   bus,
    input  logic signed [W-1:0] pcm_in
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [4:0] A_CTRL   = 5'd0;
    localparam logic [4:0] A_DIV    = 5'd1;
    localparam logic [4:0] A_TRIG   = 5'd2;
    localparam logic [4:0] A_LEN    = 5'd3;
    localparam logic [4:0] A_STATUS = 5'd4;
    localparam logic [4:0] A_RDPTR  = 5'd5;
    localparam logic [4:0] A_RDDATA = 5'd6;
    localparam logic [4:0] A_MINMAX = 5'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_CAPT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     div_act_q, div_act_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic signed [W-1:0]  level_q, level_d;
    logic signed [W-1:0]  prev_q, prev_d;
    logic                 trig_en_q, trig_en_d;
    logic                 trig_pol_q, trig_pol_d;
    logic [ADDR_W:0]      len_q, len_d;
    logic [ADDR_W-1:0]    rdptr_q, rdptr_d;
    logic [W-1:0]         rd_word_q;
    logic [W-1:0]         buf_mem [DEPTH];

    logic                 wr_en, rd_en, start_cmd, abort_cmd;
    logic                 tick, rise_hit, fall_hit, trig_hit;
    logic [ADDR_W:0]      eff_len, count_inc;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [31:0]          rd_mux;
    logic [31:0]          minmax_word;
    logic                 unused_wr_bits;

    assign wr_en     = bus.cs & bus.write;
    assign rd_en     = bus.cs & bus.read;
    assign start_cmd = wr_en && (bus.addr == A_CTRL) && bus.wr_data[0] && !bus.wr_data[1];
    assign abort_cmd = wr_en && (bus.addr == A_CTRL) && bus.wr_data[1];
    assign unused_wr_bits = ^bus.wr_data;

    // Configuration registers and the CPU-side read pointer
    always_comb begin
        div_d      = div_q;
        level_d    = level_q;
        trig_en_d  = trig_en_q;
        trig_pol_d = trig_pol_q;
        len_d      = len_q;
        rdptr_d    = rdptr_q;
        if (wr_en) begin
            case (bus.addr)
                A_DIV:   div_d = bus.wr_data[DIV_W-1:0];
                A_TRIG: begin
                    level_d    = $signed(bus.wr_data[W-1:0]);
                    trig_en_d  = bus.wr_data[16];
                    trig_pol_d = bus.wr_data[17];
                end
                A_LEN:   len_d   = bus.wr_data[ADDR_W:0];
                A_RDPTR: rdptr_d = bus.wr_data[ADDR_W-1:0];
                default: ;
            endcase
        end
        if (rd_en && (bus.addr == A_RDDATA)) begin
            rdptr_d = rdptr_q + 1'b1;
        end
    end

    // A new DIV is adopted at the next tick so the current period always completes
    assign tick = (div_cnt_q == div_act_q);

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        div_act_d = tick ? div_q : div_act_q;
        if (start_cmd) begin
            div_cnt_d = '0;
            div_act_d = div_q;
        end
        prev_d = tick ? pcm_in : prev_q;
    end

    assign rise_hit  = (prev_q < level_q) && (pcm_in >= level_q);
    assign fall_hit  = (prev_q > level_q) && (pcm_in <= level_q);
    assign trig_hit  = trig_pol_q ? fall_hit : rise_hit;
    assign eff_len   = ((len_q == '0) || (len_q > DEPTH_L)) ? DEPTH_L : len_q;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = count_q[ADDR_W-1:0];
        case (state_q)
            S_ARMED: begin
                if (tick && (!trig_en_q || trig_hit)) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    count_d   = {{ADDR_W{1'b0}}, 1'b1};
                    state_d   = (eff_len == {{ADDR_W{1'b0}}, 1'b1}) ? S_DONE : S_CAPT;
                end
            end
            S_CAPT: begin
                if (tick) begin
                    // LEN may have shrunk below the count mid-capture: finish without writing
                    if (count_q >= eff_len) begin
                        state_d = S_DONE;
                    end else begin
                        mem_we  = 1'b1;
                        count_d = count_inc;
                        if (count_inc == eff_len) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: ;
        endcase
        if (start_cmd) begin
            state_d = S_ARMED;
            count_d = '0;
            mem_we  = 1'b0;
        end
        if (abort_cmd) begin
            state_d = S_IDLE;
            count_d = count_q;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            div_q      <= '0;
            div_act_q  <= '0;
            div_cnt_q  <= '0;
            level_q    <= '0;
            prev_q     <= '0;
            trig_en_q  <= 1'b0;
            trig_pol_q <= 1'b0;
            len_q      <= '0;
            rdptr_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            div_q      <= div_d;
            div_act_q  <= div_act_d;
            div_cnt_q  <= div_cnt_d;
            level_q    <= level_d;
            prev_q     <= prev_d;
            trig_en_q  <= trig_en_d;
            trig_pol_q <= trig_pol_d;
            len_q      <= len_d;
            rdptr_q    <= rdptr_d;
        end
    end

    // Capture buffer: write port from the FSM, registered read port at the CPU pointer
    always_ff @(posedge clk) begin
        if (mem_we) begin
            buf_mem[mem_waddr] <= pcm_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_word_q <= '0;
        end else begin
            rd_word_q <= buf_mem[rdptr_q];
        end
    end

`ifdef PCM_SAMPLER_MINMAX_EN
    localparam logic signed [W-1:0] POS_FS = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] NEG_FS = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] min_q, min_d, max_q, max_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (mem_we) begin
            if (pcm_in < min_q) min_d = pcm_in;
            if (pcm_in > max_q) max_d = pcm_in;
        end
        if (start_cmd) begin
            min_d = POS_FS;
            max_d = NEG_FS;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    if (W >= 16) begin : g_mm_wide
        assign minmax_word = {max_q[W-1 -: 16], min_q[W-1 -: 16]};
    end else begin : g_mm_narrow
        assign minmax_word = {16'($signed(max_q)), 16'($signed(min_q))};
    end
`else
    assign minmax_word = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            A_DIV:    rd_mux[DIV_W-1:0] = div_q;
            A_TRIG: begin
                rd_mux[W-1:0] = level_q;
                rd_mux[16]    = trig_en_q;
                rd_mux[17]    = trig_pol_q;
            end
            A_LEN:    rd_mux[ADDR_W:0] = len_q;
            A_STATUS: begin
                rd_mux[1:0]             = state_q;
                rd_mux[ADDR_W+16:16]    = count_q;
            end
            A_RDPTR:  rd_mux[ADDR_W-1:0] = rdptr_q;
            A_RDDATA: rd_mux = 32'($signed(rd_word_q));
            A_MINMAX: rd_mux = minmax_word;
            default:  ;
        endcase
    end

    assign bus.rd_data = rd_mux;

endmodule

// File: tb/tb_pcm_sampler_core.sv
// Randomized and directed bench for pcm_sampler_core: records every PCM sample it drives and
// predicts the captured buffer from tick arithmetic on that history.
module tb_pcm_sampler_core;
    localparam int W     = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int HMAX  = 40000;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [W-1:0] pcm_in;

    pcm_sampler_core_if bus ();

    pcm_sampler_core #(.W(W), .ADDR_W(AW), .DIV_W(16)) dut (
        .clk    (clk),
        .reset  (rst_n),
        .bus    (bus),
        .pcm_in (pcm_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_rd_cyc = 0;
    int pcm_mode = 0;
    logic signed [W-1:0] pcm_set = '0;
    logic signed [W-1:0] hist [HMAX];
    logic signed [W-1:0] exp_buf [DEPTH];

    // History of the sample seen at each rising edge, and the edge that carried START
    always @(posedge clk) begin
        if (cyc < HMAX) hist[cyc] <= pcm_in;
        cyc <= cyc + 1;
        if (bus.cs && bus.write && bus.addr == 5'd0 && bus.wr_data[1:0] == 2'b01)
            start_cyc <= cyc;
    end

    // PCM source: 0 = hold pcm_set, 1 = ramp +1 per clock, 2 = random in [-200,200]
    initial begin
        pcm_in = '0;
        forever begin
            @(negedge clk);
            case (pcm_mode)
                0:       pcm_in = pcm_set;
                1:       pcm_in = pcm_in + 1'b1;
                default: pcm_in = W'($urandom_range(0, 400)) - W'(200);
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
        $display("wr addr=%0d data=0x%08h", a, d);
        @(negedge clk);
        bus.cs = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
        #1;
        d = bus.rd_data;
        last_rd_cyc = cyc;
        $display("rd addr=%0d data=0x%08h", a, d);
        @(negedge clk);
        bus.cs = 1'b0; bus.read = 1'b0;
    endtask

    task automatic run_capture(input string name, input int d, input int len, input bit ten,
                               input bit pol, input int lvl, input int pre, input int mode,
                               input int budget);
        logic [31:0] st, v, exp_mm;
        int horizon, len_eff, found, pv, cur, t, exp_state, exp_cnt, mn, mx;
        pcm_mode = 0;
        pcm_set  = W'(pre);
        bus_write(5'd1, 32'(d));
        bus_write(5'd2, {14'd0, pol, ten, 16'(lvl)});
        bus_write(5'd3, 32'(len));
        repeat (15) @(negedge clk);
        bus_write(5'd0, 32'd1);
        pcm_mode = mode;
        st = '0;
        for (int i = 0; i < budget; i++) begin
            bus_read(5'd4, st);
            if (st[1:0] == 2'd3) break;
        end
        horizon = last_rd_cyc - 1;

        // Ticks land every d+1 edges after the START edge; the first qualifying one is sample 0
        len_eff = (len == 0 || len > DEPTH) ? DEPTH : len;
        pv = int'(hist[start_cyc]);
        found = -1;
        for (int k = 1; start_cyc + (d + 1) * k <= horizon; k++) begin
            cur = int'(hist[start_cyc + (d + 1) * k]);
            if (!ten || (!pol && pv < lvl && cur >= lvl) || (pol && pv > lvl && cur <= lvl)) begin
                found = k;
                break;
            end
            pv = cur;
        end
        exp_cnt = 0;
        if (found < 0) begin
            exp_state = 1;
        end else begin
            for (int i = 0; i < len_eff; i++) begin
                t = start_cyc + (d + 1) * (found + i);
                if (t > horizon) break;
                exp_buf[i] = hist[t];
                exp_cnt++;
            end
            exp_state = (exp_cnt == len_eff) ? 3 : 2;
        end
        check({name, "_state"}, 32'(st[1:0]), 32'(exp_state));
        check({name, "_count"}, 32'(st[AW+16:16]), 32'(exp_cnt));

        bus_write(5'd5, 32'd0);
        for (int i = 0; i < exp_cnt; i++) begin
            bus_read(5'd6, v);
            check($sformatf("%s_buf%0d", name, i), v, 32'(exp_buf[i]));
        end
        bus_read(5'd5, v);
        check({name, "_rdptr"}, v, 32'(exp_cnt % DEPTH));

        if (exp_cnt > 0) begin
            mn = 32767;
            mx = -32768;
            for (int i = 0; i < exp_cnt; i++) begin
                if (int'(exp_buf[i]) < mn) mn = int'(exp_buf[i]);
                if (int'(exp_buf[i]) > mx) mx = int'(exp_buf[i]);
            end
`ifdef PCM_SAMPLER_MINMAX_EN
            exp_mm = {16'(mx), 16'(mn)};
`else
            exp_mm = 32'd0;
`endif
            bus_read(5'd7, v);
            check({name, "_minmax"}, v, exp_mm);
        end
    endtask

    initial begin
        logic [31:0] v, a;
        int d, len, lvl, pre;
        bit ten, pol;

        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.addr = '0; bus.wr_data = '0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        #1;
        check("rst_rd_addr0", bus.rd_data, 32'd0);
        bus_read(5'd4, v); check("rst_status", v, 32'd0);
        bus_read(5'd5, v); check("rst_rdptr", v, 32'd0);
        bus_read(5'd6, v); check("rst_rddata", v, 32'd0);
        bus_read(5'd5, v); check("rdptr_autoinc", v, 32'd1);
        bus_read(5'd9, v); check("unmapped", v, 32'd0);
        bus_read(5'd7, v); check("rst_minmax", v, 32'd0);

        // Ramp capture, DIV=3 LEN=8: samples must be spaced by 4
        run_capture("ramp", 3, 8, 1'b0, 1'b0, 0, 1, 1, 100);
        bus_write(5'd5, 32'd0);
        bus_read(5'd6, a);
        bus_read(5'd6, v);
        check("ramp_step", v - a, 32'd4);
        bus_read(5'd4, v);
        check("ramp_status", v, 32'h0008_0003);

        // Rising trigger at 100 on a 90.. ramp: sample 0 is exactly 100
        run_capture("trig_rise", 0, 4, 1'b1, 1'b0, 100, 90, 1, 60);
        bus_write(5'd5, 32'd0);
        bus_read(5'd6, v);
        check("trig_rise_first", v, 32'd100);

        // Falling polarity on a rising ramp never fires
        run_capture("trig_fall", 0, 4, 1'b1, 1'b1, 100, 90, 1, 15);
        bus_read(5'd4, v);
        check("trig_fall_armed", v, 32'h0000_0001);
        bus_write(5'd0, 32'd2);

        run_capture("len0", 0, 0, 1'b0, 1'b0, 0, 0, 2, 60);
        bus_read(5'd4, v);
        check("len0_status", v, 32'h0010_0003);
        run_capture("len1", 2, 1, 1'b0, 1'b0, 0, 0, 2, 30);
        bus_read(5'd4, v);
        check("len1_status", v, 32'h0001_0003);
        run_capture("len_big", 1, 20, 1'b0, 1'b0, 0, 0, 2, 80);

        // ABORT between the 5th and 6th tick keeps count=5
        pcm_mode = 2;
        bus_write(5'd1, 32'd9);
        bus_write(5'd2, 32'd0);
        bus_write(5'd3, 32'd16);
        bus_write(5'd0, 32'd1);
        for (int i = 0; i < 200 && cyc < start_cyc + 52; i++) @(negedge clk);
        bus_write(5'd0, 32'd2);
        bus_read(5'd4, v);
        check("abort_status", v, 32'h0005_0000);

        bus_write(5'd0, 32'd1);
        repeat (20) @(negedge clk);
        bus_write(5'd0, 32'd3);
        bus_read(5'd4, v);
        check("start_abort_state", 32'(v[1:0]), 32'd0);

        // Reset asserted mid-capture clears state and count at once
        bus_write(5'd0, 32'd1);
        repeat (35) @(negedge clk);
        bus_read(5'd4, v);
        check("pre_rst_status", v, 32'h0003_0002);
        @(negedge clk);
        rst_n = 1'b0;
        bus.cs = 1'b1; bus.read = 1'b1; bus.addr = 5'd4;
        #1;
        check("mid_rst_status", bus.rd_data, 32'd0);
        bus.addr = 5'd6;
        #1;
        check("mid_rst_rddata", bus.rd_data, 32'd0);
        @(negedge clk);
        bus.cs = 1'b0; bus.read = 1'b0; bus.addr = 5'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int it = 0; it < 8; it++) begin
            d   = int'($urandom_range(0, 5));
            len = int'($urandom_range(0, 20));
            ten = 1'($urandom_range(0, 1));
            pol = 1'($urandom_range(0, 1));
            lvl = int'($urandom_range(0, 100)) - 50;
            pre = ten ? (pol ? 300 : -300) : int'($urandom_range(0, 100));
            run_capture($sformatf("rnd%0d", it), d, len, ten, pol, lvl, pre, 2,
                        ((d + 1) * (DEPTH + 40)) / 2 + 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
